// File: rtl/rtc_time_keeper.sv
// 24h hh:mm:ss time-of-day counter with 1 Hz prescaler and a validated load path.
// A load request is staged, range-checked for one cycle, then applied with the prescaler cleared.
module rtc_time_keeper #(
  parameter int CLK_DIV = 50_000_000,
  parameter int DIV_W   = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  input  logic       update,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  input  logic [5:0] load_seconds,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_ack,
  output logic       load_err
);

  typedef enum logic [1:0] {RUN, CHECK, LOAD} state_t;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div;
  logic             update_q;
  logic [4:0]       stg_h;
  logic [5:0]       stg_m, stg_s;
  logic             tick, rise, stg_ok;

  assign tick   = (div == DIV_MAX) & ~hold;
  assign rise   = update & ~update_q;
  assign stg_ok = (stg_h <= 5'd23) && (stg_m <= 6'd59) && (stg_s <= 6'd59);

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (rise) state_nxt = CHECK;
      CHECK:   state_nxt = stg_ok ? LOAD : RUN;
      LOAD:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= RUN;
      div      <= '0;
      update_q <= 1'b0;
      stg_h    <= '0;
      stg_m    <= '0;
      stg_s    <= '0;
      hours    <= '0;
      minutes  <= '0;
      seconds  <= '0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_ack <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      update_q <= update;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      load_ack <= 1'b0;
      load_err <= 1'b0;

      // LOAD restarts the second so the loaded time lasts a full CLK_DIV clocks
      if (state == LOAD)  div <= '0;
      else if (tick)      div <= '0;
      else if (!hold)     div <= div + 1'b1;

      if (state == RUN && rise) begin
        stg_h <= load_hours;
        stg_m <= load_minutes;
        stg_s <= load_seconds;
      end

      // ticks landing in CHECK/LOAD are dropped
      if (state == RUN && tick) begin
        sec_tick <= 1'b1;
        if (seconds == 6'd59) begin
          seconds <= '0;
          if (minutes == 6'd59) begin
            minutes <= '0;
            if (hours == 5'd23) begin
              hours    <= '0;
              day_wrap <= 1'b1;
            end else begin
              hours <= hours + 1'b1;
            end
          end else begin
            minutes <= minutes + 1'b1;
          end
        end else begin
          seconds <= seconds + 1'b1;
        end
      end

      if (state == CHECK && !stg_ok) load_err <= 1'b1;

      if (state == LOAD) begin
        hours    <= stg_h;
        minutes  <= stg_m;
        seconds  <= stg_s;
        load_ack <= 1'b1;
      end
    end
  end

endmodule
